// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: control, training and fetch-address signals between the pipeline and the PC generator.
interface fetch_pc_gen_if #(parameter int XLEN = 32);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            resolve_valid;
  logic [XLEN-1:0] resolve_pc;
  logic            resolve_taken;
  logic [XLEN-1:0] resolve_target;
  logic            trap;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pred_taken;
  logic            misaligned;
  modport master (
    output stall, redirect_valid, redirect_target, resolve_valid, resolve_pc,
           resolve_taken, resolve_target, trap,
    input  pc, pc_valid, pred_taken, misaligned
  );
  modport slave (
    input  stall, redirect_valid, redirect_target, resolve_valid, resolve_pc,
           resolve_taken, resolve_target, trap,
    output pc, pc_valid, pred_taken, misaligned
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC sequencer with trap/redirect/stall priority and a direct-mapped BTB predictor.
module fetch_pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              BTB_DEPTH    = 16
) (
  input logic           clk,
  input logic           reset,
  fetch_pc_gen_if.slave bus
);
  localparam int IW = $clog2(BTB_DEPTH);
  localparam int TW = XLEN - IW - 2;
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            misaligned, misaligned_next;
  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TW-1:0]        btb_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      btb_target [BTB_DEPTH];
  logic [1:0]           btb_ctr    [BTB_DEPTH];
  logic [IW-1:0] idx, r_idx;
  logic [TW-1:0] tag, r_tag;
  logic          pred_taken, r_hit;
  assign idx   = pc[IW+1:2];
  assign tag   = pc[XLEN-1:IW+2];
  assign r_idx = bus.resolve_pc[IW+1:2];
  assign r_tag = bus.resolve_pc[XLEN-1:IW+2];
  assign r_hit = btb_valid[r_idx] && btb_tag[r_idx] == r_tag;
  // Lookup reads the arrays combinationally, so a same-edge update is only seen next cycle.
  assign pred_taken = state == RUN && btb_valid[idx] && btb_tag[idx] == tag && btb_ctr[idx][1];
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    misaligned_next = misaligned;
    if (bus.trap) begin
      state_next      = RUN;
      pc_next         = TRAP_VECTOR;
      misaligned_next = 1'b0;
    end else if (state == BOOT) begin
      state_next = RUN;
    end else if (state == RUN) begin
      if (bus.redirect_valid) begin
        if (bus.redirect_target[1:0] == 2'b00) begin
          pc_next = bus.redirect_target;
        end else begin
          state_next      = FAULT;
          misaligned_next = 1'b1;
        end
      end else if (!bus.stall) begin
        pc_next = pred_taken ? btb_target[idx] : pc + XLEN'(4);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      misaligned <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      misaligned <= misaligned_next;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btb_valid <= '0;
    else if (bus.resolve_valid && !r_hit && bus.resolve_taken) btb_valid[r_idx] <= 1'b1;
  end
  // Payload arrays carry no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (bus.resolve_valid) begin
      if (r_hit) begin
        btb_ctr[r_idx] <= bus.resolve_taken ? (btb_ctr[r_idx] == 2'd3 ? 2'd3 : btb_ctr[r_idx] + 2'd1)
                                            : (btb_ctr[r_idx] == 2'd0 ? 2'd0 : btb_ctr[r_idx] - 2'd1);
        if (bus.resolve_taken) btb_target[r_idx] <= bus.resolve_target;
      end else if (bus.resolve_taken) begin
        btb_tag[r_idx]    <= r_tag;
        btb_target[r_idx] <= bus.resolve_target;
        btb_ctr[r_idx]    <= 2'd2;
      end
    end
  end
  assign bus.pc         = pc;
  assign bus.pc_valid   = state == RUN;
  assign bus.pred_taken = pred_taken;
  assign bus.misaligned = misaligned;
endmodule
